// File: rtl/i_decode.sv
// i_decode - LEGv8 single-cycle instruction-decode stage.
//
// Holds the 32 x 64-bit register file (X31 = XZR), slices the instruction
// into register indices, generates the main control signals and produces
// the sign-extended (unshifted) immediate for the execute stage.
//
// Ports:
//   clk                  in   rising-edge clock
//   reset                in   synchronous active-high; zeroes the register file
//   instruction          in   32-bit instruction from fetch
//   write_data           in   write-back value for Rd/Rt
//   read_data1           out  X[Rn]
//   read_data2           out  X[Rm] or X[Rt] depending on reg2_loc
//   sign_extended_output out  sign-extended immediate (no <<2 applied here)
//   opcode               out  instruction[31:21]
//   alu_op               out  ALUOp class for execute
//   alu_src .. uncond_branch  out  single-bit control signals

`ifndef WORD
`define WORD 64
`endif

// 11-bit R-type / D-type opcodes
`ifndef ADD
`define ADD  11'b10001011000
`endif
`ifndef SUB
`define SUB  11'b11001011000
`endif
`ifndef AND
`define AND  11'b10001010000
`endif
`ifndef ORR
`define ORR  11'b10101010000
`endif
`ifndef LDUR
`define LDUR 11'b11111000010
`endif
`ifndef STUR
`define STUR 11'b11111000000
`endif
// Shorter prefixes: CBZ on [31:24], B on [31:26]
`ifndef CBZ
`define CBZ  8'b10110100
`endif
`ifndef B
`define B    6'b000101
`endif

`ifndef ALUOp_DTYPE
`define ALUOp_DTYPE 2'b00
`endif
`ifndef ALUOp_CBZ
`define ALUOp_CBZ   2'b01
`endif
`ifndef ALUOp_RTYPE
`define ALUOp_RTYPE 2'b10
`endif
`ifndef ALUOp_B
`define ALUOp_B     2'b11
`endif

module i_decode (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        instruction,
    input  logic [`WORD-1:0]   write_data,
    output logic [`WORD-1:0]   read_data1,
    output logic [`WORD-1:0]   read_data2,
    output logic [`WORD-1:0]   sign_extended_output,
    output logic [10:0]        opcode,
    output logic [1:0]         alu_op,
    output logic               alu_src,
    output logic               reg2_loc,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               branch,
    output logic               uncond_branch
);

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_RTYPE,
        CLS_LDUR,
        CLS_STUR,
        CLS_CBZ,
        CLS_B
    } insn_class_e;

    localparam logic [4:0] XZR = 5'd31;

    // ------------------------------------------------------------------
    // Field slicing
    // ------------------------------------------------------------------
    logic [4:0] rn;
    logic [4:0] rd;
    logic [4:0] rm;
    logic [4:0] read_reg2;

    assign rn        = instruction[9:5];
    assign rd        = instruction[4:0];
    assign rm        = instruction[20:16];
    assign read_reg2 = reg2_loc ? rd : rm;
    assign opcode    = instruction[31:21];

    // ------------------------------------------------------------------
    // Instruction classification (longest defining prefix first)
    // ------------------------------------------------------------------
    insn_class_e cls;

    always_comb begin
        cls = CLS_NONE;
        if (instruction[31:21] == `ADD || instruction[31:21] == `SUB ||
            instruction[31:21] == `AND || instruction[31:21] == `ORR) begin
            cls = CLS_RTYPE;
        end else if (instruction[31:21] == `LDUR) begin
            cls = CLS_LDUR;
        end else if (instruction[31:21] == `STUR) begin
            cls = CLS_STUR;
        end else if (instruction[31:24] == `CBZ) begin
            cls = CLS_CBZ;
        end else if (instruction[31:26] == `B) begin
            cls = CLS_B;
        end
    end

    // ------------------------------------------------------------------
    // Control signals
    // ------------------------------------------------------------------
    always_comb begin
        alu_op        = `ALUOp_DTYPE;
        alu_src       = 1'b0;
        reg2_loc      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        branch        = 1'b0;
        uncond_branch = 1'b0;
        unique case (cls)
            CLS_RTYPE: begin
                alu_op    = `ALUOp_RTYPE;
                reg_write = 1'b1;
            end
            CLS_LDUR: begin
                alu_op     = `ALUOp_DTYPE;
                alu_src    = 1'b1;
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            CLS_STUR: begin
                alu_op    = `ALUOp_DTYPE;
                reg2_loc  = 1'b1;
                alu_src   = 1'b1;
                mem_write = 1'b1;
            end
            CLS_CBZ: begin
                alu_op   = `ALUOp_CBZ;
                reg2_loc = 1'b1;
                branch   = 1'b1;
            end
            CLS_B: begin
                alu_op        = `ALUOp_B;
                uncond_branch = 1'b1;
            end
            default: begin
                alu_op = `ALUOp_DTYPE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Immediate generation (unshifted; execute applies <<2 for branches)
    // ------------------------------------------------------------------
    always_comb begin
        sign_extended_output = '0;
        unique case (cls)
            CLS_LDUR, CLS_STUR:
                sign_extended_output = {{(`WORD-9){instruction[20]}}, instruction[20:12]};
            CLS_CBZ:
                sign_extended_output = {{(`WORD-19){instruction[23]}}, instruction[23:5]};
            CLS_B:
                sign_extended_output = {{(`WORD-26){instruction[25]}}, instruction[25:0]};
            default:
                sign_extended_output = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Register file: combinational reads, single write port on clk
    // ------------------------------------------------------------------
    logic [`WORD-1:0] rf_q [32];
    logic             wr_en_d;

    // Writes to XZR are discarded at the port so rf_q[31] stays zero;
    // reads of index 31 are also forced to zero so XZR never depends on storage.
    assign wr_en_d = reg_write && (rd != XZR);

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_q <= '{default: '0};
        end else if (wr_en_d) begin
            rf_q[rd] <= write_data;
        end
    end

    assign read_data1 = (rn == XZR)        ? '0 : rf_q[rn];
    assign read_data2 = (read_reg2 == XZR) ? '0 : rf_q[read_reg2];

endmodule

// File: tb/tb_i_decode.sv
module tb_i_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic [63:0] write_data;
    logic [63:0] read_data1, read_data2, sign_extended_output;
    logic [10:0] opcode;
    logic [1:0]  alu_op;
    logic        alu_src, reg2_loc, mem_read, mem_write, mem_to_reg;
    logic        reg_write, branch, uncond_branch;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    localparam logic [31:0] NOP = 32'h0000_0000;  // unrecognized: no write

    i_decode dut (
        .clk                  (clk),
        .reset                (reset),
        .instruction          (instruction),
        .write_data           (write_data),
        .read_data1           (read_data1),
        .read_data2           (read_data2),
        .sign_extended_output (sign_extended_output),
        .opcode               (opcode),
        .alu_op               (alu_op),
        .alu_src              (alu_src),
        .reg2_loc             (reg2_loc),
        .mem_read             (mem_read),
        .mem_write            (mem_write),
        .mem_to_reg           (mem_to_reg),
        .reg_write            (reg_write),
        .branch               (branch),
        .uncond_branch        (uncond_branch)
    );

    always #5 clk = ~clk;

    // ctrl packing: {alu_src, reg2_loc, mem_read, mem_write, mem_to_reg, reg_write, branch, uncond_branch}
    typedef struct {
        logic [31:0] instr;
        logic [63:0] rd1;
        logic [63:0] rd2;
        logic [63:0] imm;
        logic [7:0]  ctrl;
        logic [1:0]  aluop;
    } vec_t;

    vec_t tbl [14];
    vec_t sb  [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] mk_add(input logic [4:0] rdi, input logic [4:0] rni, input logic [4:0] rmi);
        return {11'b10001011000, rmi, 6'd0, rni, rdi};
    endfunction

    // Read two registers through an ADD X0,Xa,Xb held only between edges.
    task automatic rd_regs(input logic [4:0] a, input logic [4:0] b,
                           input logic [63:0] ea, input logic [63:0] eb, input string nm);
        @(negedge clk);
        instruction = mk_add(5'd0, a, b);
        #1;
        chk({nm, ".rd1"}, read_data1, ea);
        chk({nm, ".rd2"}, read_data2, eb);
        #1 instruction = NOP;
    endtask

    task automatic wr_reg(input logic [4:0] idx, input logic [63:0] val);
        @(negedge clk);
        instruction = mk_add(idx, 5'd31, 5'd31);
        write_data  = val;
        @(posedge clk);
        #1;
        instruction = NOP;
        write_data  = '0;
    endtask

    // Execute one non-R instruction across an edge with a junk write value.
    task automatic clock_insn(input logic [31:0] ins, input logic [63:0] wd);
        @(negedge clk);
        instruction = ins;
        write_data  = wd;
        @(posedge clk);
        #1;
        instruction = NOP;
        write_data  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t e;
        reset       = 1'b1;
        instruction = NOP;
        write_data  = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Every register reads zero after reset.
        for (int i = 0; i < 32; i++)
            rd_regs(5'(i), 5'(i), 64'd0, 64'd0, $sformatf("reset_x%0d", i));

        // LDUR X9,[X22,#64] then write-back 16 into X9.
        @(negedge clk);
        instruction = 32'hF84402C9;
        write_data  = 64'd16;
        #1;
        chk("ldur.rd1", read_data1, 64'd0);
        chk("ldur.imm", sign_extended_output, 64'd64);
        chk("ldur.ctrl", {56'd0, alu_src, reg2_loc, mem_read, mem_write, mem_to_reg, reg_write, branch, uncond_branch}, 64'hAC);
        chk("ldur.aluop", {62'd0, alu_op}, 64'd0);
        chk("ldur.opcode", {53'd0, opcode}, 64'h7C2);
        @(posedge clk);
        #1 instruction = NOP;
        rd_regs(5'd9, 5'd9, 64'd16, 64'd16, "ldur_wb");

        wr_reg(5'd19, 64'd10);
        wr_reg(5'd9,  64'd20);
        wr_reg(5'd11, 64'd88);

        tbl[0]  = '{32'h8B09026A, 64'd10, 64'd20, 64'd0, 8'h04, 2'b10};        // ADD X10,X19,X9
        tbl[1]  = '{32'hCB09026A, 64'd10, 64'd20, 64'd0, 8'h04, 2'b10};        // SUB
        tbl[2]  = '{32'h8A09026A, 64'd10, 64'd20, 64'd0, 8'h04, 2'b10};        // AND
        tbl[3]  = '{32'hAA09026A, 64'd10, 64'd20, 64'd0, 8'h04, 2'b10};        // ORR
        tbl[4]  = '{32'hF84402C9, 64'd0,  64'd0,  64'd64, 8'hAC, 2'b00};       // LDUR
        tbl[5]  = '{32'hF81FF269, 64'd10, 64'd20, 64'hFFFF_FFFF_FFFF_FFFF, 8'hD0, 2'b00}; // STUR X9,[X19,#-1]
        tbl[6]  = '{32'hB4FFFF6B, 64'd0,  64'd88, 64'hFFFF_FFFF_FFFF_FFFB, 8'h42, 2'b01}; // CBZ X11,-5
        tbl[7]  = '{32'hB400009F, 64'd0,  64'd0,  64'd4,  8'h42, 2'b01};       // CBZ X31,+4
        tbl[8]  = '{32'h14000040, 64'd0,  64'd0,  64'd64, 8'h01, 2'b11};       // B 64
        tbl[9]  = '{32'h17FFFFFF, 64'd0,  64'd0,  64'hFFFF_FFFF_FFFF_FFFF, 8'h01, 2'b11}; // B -1
        tbl[10] = '{32'h00000000, 64'd0,  64'd0,  64'd0,  8'h00, 2'b00};       // unrecognized
        tbl[11] = '{32'hFFFFFFFF, 64'd0,  64'd0,  64'd0,  8'h00, 2'b00};       // unrecognized
        tbl[12] = '{32'hF8640269, 64'd10, 64'd0,  64'd0,  8'h00, 2'b00};       // near-miss LDUR
        tbl[13] = '{32'h8B1303E9, 64'd0,  64'd10, 64'd0,  8'h04, 2'b10};       // ADD X9,XZR,X19

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            instruction = tbl[i].instr;
            sb.push_back(tbl[i]);
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d.rd1", i), read_data1, e.rd1);
            chk($sformatf("v%0d.rd2", i), read_data2, e.rd2);
            chk($sformatf("v%0d.imm", i), sign_extended_output, e.imm);
            chk($sformatf("v%0d.ctrl", i),
                {56'd0, alu_src, reg2_loc, mem_read, mem_write, mem_to_reg, reg_write, branch, uncond_branch},
                {56'd0, e.ctrl});
            chk($sformatf("v%0d.aluop", i), {62'd0, alu_op}, {62'd0, e.aluop});
            chk($sformatf("v%0d.opcode", i), {53'd0, opcode}, {53'd0, e.instr[31:21]});
            #1 instruction = NOP;
        end

        // Non-writing classes leave the register file untouched.
        clock_insn(32'h14000040, 64'hBAD);     // B, Rd field = 0
        clock_insn(32'hF81FF269, 64'h77);      // STUR, Rt = 9
        clock_insn(32'hB4FFFF6B, 64'h55);      // CBZ, Rt = 11
        clock_insn(32'h00000005, 64'h123);     // unrecognized, Rd field = 5
        rd_regs(5'd0, 5'd9,  64'd0, 64'd20, "nowr_a");
        rd_regs(5'd11, 5'd5, 64'd88, 64'd0, "nowr_b");

        // XZR write discarded; X30 unaffected.
        wr_reg(5'd30, 64'h1234);
        @(negedge clk);
        instruction = mk_add(5'd31, 5'd31, 5'd30);
        write_data  = 64'hDEAD;
        #1;
        chk("xzr_pre.rd1", read_data1, 64'd0);
        chk("xzr_pre.rd2", read_data2, 64'h1234);
        @(posedge clk);
        #1;
        chk("xzr_post.rd1", read_data1, 64'd0);
        chk("xzr_post.rd2", read_data2, 64'h1234);
        instruction = NOP;
        rd_regs(5'd31, 5'd30, 64'd0, 64'h1234, "xzr_read");

        // No write-through: old value until the edge, new value after.
        wr_reg(5'd7, 64'd1);
        @(negedge clk);
        instruction = mk_add(5'd7, 5'd7, 5'd7);
        write_data  = 64'd55;
        #1 chk("wlat_pre", read_data1, 64'd1);
        @(posedge clk);
        #1 chk("wlat_post", read_data1, 64'd55);
        instruction = NOP;

        // Back-to-back writes to the same register: last edge wins.
        @(negedge clk);
        instruction = mk_add(5'd8, 5'd8, 5'd31);
        write_data  = 64'd3;
        @(negedge clk);
        chk("b2b_first", read_data1, 64'd3);
        write_data  = 64'd4;
        @(posedge clk);
        #1 instruction = NOP;
        rd_regs(5'd8, 5'd8, 64'd4, 64'd4, "b2b_last");

        // Reset collides with a write to X5: reset wins, then write lands.
        wr_reg(5'd5, 64'd7);
        @(negedge clk);
        instruction = mk_add(5'd5, 5'd5, 5'd5);
        write_data  = 64'd9;
        reset       = 1'b1;
        #1;
        chk("rst_pre.rd1", read_data1, 64'd7);
        chk("rst_ctrl_live", {63'd0, reg_write}, 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_coll.x5", read_data1, 64'd0);
        @(posedge clk);
        #1;
        chk("rst_after.x5", read_data1, 64'd9);
        instruction = NOP;
        write_data  = '0;
        rd_regs(5'd9, 5'd30, 64'd0, 64'd0, "rst_cleared");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
